// File: rtl/pq_pkg.sv
// pq_pkg: shared widths, key/value pair type and scheduler states.
package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;
  typedef enum logic [1:0] {STOP, RUN, FLUSH} sched_state_t;
endpackage

// File: rtl/pq_release_sched_if.sv
// pq_release_sched_if: PQ head/pop signals plus the released-entry valid/ready stream.
interface pq_release_sched_if #(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH
);
  logic pq_empty, pq_deq, m_valid, m_ready;
  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo, m_kv;
  modport master(input pq_empty, pq_kvo, m_ready, output pq_deq, m_valid, m_kv);
  modport slave(output pq_empty, pq_kvo, m_ready, input pq_deq, m_valid, m_kv);
endinterface

// File: rtl/pq_release_sched_fifo.sv
// kv_fifo2: 2-entry in-order register FIFO; dout is the registered head.
module kv_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] r1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout <= '0;
      r1   <= '0;
      cnt  <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (push) r1 <= din;
      // head reloads from the tail when full, otherwise straight from din
      if (pop ? (cnt == 2'd2 || push) : (push && cnt == 2'd0))
        dout <= (pop && cnt == 2'd2) ? r1 : din;
    end
endmodule

// File: rtl/pq_release_sched.sv
// pq_release_sched: pops PQ entries whose key (release time) has been reached, with run/stop and flush.
module pq_release_sched #(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 flush,
  pq_release_sched_if.master   bus,
  output logic [KEY_WIDTH-1:0] now,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] rel_cnt
);
  import pq_pkg::*;
  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  sched_state_t state, state_n;
  logic [1:0] fifo_cnt;
  logic [KEY_WIDTH-1:0] d;
  logic eligible, space, pop;
  // serial compare: key <= now within a half-range window, wrap-safe
  assign d = now - bus.pq_kvo[KVW-1 -: KEY_WIDTH];
  assign eligible = !d[KEY_WIDTH-1];
  assign pop = bus.m_valid && bus.m_ready;
  assign space = fifo_cnt < 2'd2 || pop;
  assign bus.pq_deq = !bus.pq_empty && space && (state == FLUSH || (state == RUN && eligible));
  assign bus.m_valid = fifo_cnt != 2'd0;
  always_comb begin
    state_n = state;
    state_n = state == FLUSH ? (bus.pq_empty ? (en ? RUN : STOP) : FLUSH)
            : flush ? FLUSH : en ? RUN : STOP;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= STOP;
      now        <= '0;
      flush_done <= 1'b0;
      rel_cnt    <= '0;
    end else begin
      state      <= state_n;
      flush_done <= state == FLUSH && bus.pq_empty;
      if (tick && state != STOP) now <= now + 1'b1;
      if (bus.pq_deq && !(&rel_cnt)) rel_cnt <= rel_cnt + 1'b1;
    end
  kv_fifo2 #(.W(KVW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.pq_deq),
    .pop  (pop),
    .din  (bus.pq_kvo),
    .dout (bus.m_kv),
    .cnt  (fifo_cnt)
  );
endmodule

// File: tb/tb_pq_release_sched.sv
// tb_pq_release_sched: PQ model feeding the scheduler, output scoreboard, per-feature tasks.
module tb_pq_release_sched;
  localparam int KW = 4;
  localparam int VW = 8;
  localparam int KVW = KW + VW;
  logic clk, rst, en, tick, flush, flush_done;
  logic [KW-1:0] now;
  logic [1:0] rel_cnt;
  int vectors = 0, errors = 0;
  int cyc = 0, deq_count = 0, hs_count = 0;
  logic deq_pend = 1'b0;
  logic [KVW-1:0] pq_q[$], exp_q[$];
  int deq_now[$], deq_cyc[$];

  pq_release_sched_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW)) bus ();

  pq_release_sched #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .CNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tick       (tick),
    .flush      (flush),
    .bus        (bus.master),
    .now        (now),
    .flush_done (flush_done),
    .rel_cnt    (rel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [KVW-1:0] kv(input int k, input int v);
    return {k[KW-1:0], v[VW-1:0]};
  endfunction

  task automatic refresh();
    bus.pq_empty = pq_q.size() == 0;
    bus.pq_kvo = pq_q.size() == 0 ? '0 : pq_q[0];
  endtask

  task automatic load(input int k, input int v);
    pq_q.push_back(kv(k, v));
    exp_q.push_back(kv(k, v));
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    deq_pend = rst && bus.pq_deq;
    if (deq_pend) begin
      deq_count++;
      deq_now.push_back(int'(now));
      deq_cyc.push_back(cyc);
    end
    if (rst && bus.m_valid && bus.m_ready) begin
      hs_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_kv: got %h, no entry expected", bus.m_kv);
      end else begin
        logic [KVW-1:0] e;
        e = exp_q.pop_front();
        if (bus.m_kv !== e) begin
          errors++;
          $display("FAIL out_kv: got %h, expected %h", bus.m_kv, e);
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (deq_pend) begin
      deq_pend = 1'b0;
      #1;
      if (pq_q.size() > 0) void'(pq_q.pop_front());
      refresh();
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    en = 1'b0;
    tick = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    pq_q.delete();
    exp_q.delete();
    refresh();
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (now !== 4'd0) begin errors++; $display("FAIL rst_now: got %0d, expected 0", now); end
    vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", bus.m_valid); end
    vectors++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_fdone: got %b, expected 0", flush_done); end
    vectors++; if (bus.pq_deq !== 1'b0) begin errors++; $display("FAIL rst_deq: got %b, expected 0", bus.pq_deq); end
    en = 1'b1;
    tick = 1'b1;
    load(0, 8'hA1);
    load(0, 8'hA2);
    repeat (3) step();
    vectors++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL run_valid: got %b, expected 1", bus.m_valid); end
    vectors++; if (now !== 4'd2) begin errors++; $display("FAIL run_now: got %0d, expected 2", now); end
    vectors++; if (rel_cnt !== 2'd2) begin errors++; $display("FAIL run_relcnt: got %0d, expected 2", rel_cnt); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, expected 0", bus.m_valid); end
    vectors++; if (now !== 4'd0) begin errors++; $display("FAIL async_now: got %0d, expected 0", now); end
    vectors++; if (rel_cnt !== 2'd0) begin errors++; $display("FAIL async_relcnt: got %0d, expected 0", rel_cnt); end
  endtask

  task automatic test_release();
    apply_reset();
    en = 1'b1;
    tick = 1'b1;
    bus.m_ready = 1'b1;
    deq_now.delete();
    load(8, 8'h11);
    load(9, 8'h22);
    load(10, 8'h33);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL rel_timeout: %0d left, expected 0", exp_q.size()); end
    vectors++;
    if (deq_now.size() != 3) begin
      errors++; $display("FAIL rel_deqs: got %0d pops, expected 3", deq_now.size());
    end else begin
      for (int i = 0; i < 3; i++)
        if (deq_now[i] != 8 + i) begin errors++; $display("FAIL rel_time%0d: got now=%0d, expected %0d", i, deq_now[i], 8 + i); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    en = 1'b1;
    deq_count = 0;
    for (int i = 0; i < 4; i++) load(0, 8'h41 + i);
    repeat (8) step();
    vectors++; if (deq_count != 2) begin errors++; $display("FAIL bp_deqs: got %0d, expected 2", deq_count); end
    vectors++; if (bus.pq_deq !== 1'b0) begin errors++; $display("FAIL bp_deq_low: got %b, expected 0", bus.pq_deq); end
    vectors++; if (bus.m_kv !== kv(0, 8'h41)) begin errors++; $display("FAIL bp_hold: got %h, expected %h", bus.m_kv, kv(0, 8'h41)); end
    bus.m_ready = 1'b1;
    hs_count = 0;
    repeat (4) step();
    vectors++; if (hs_count != 4) begin errors++; $display("FAIL bp_stream: got %0d outputs in 4 cycles, expected 4", hs_count); end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    apply_reset();
    en = 1'b1;
    tick = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40 && now != 4'd15; i++) step();
    tick = 1'b0;
    vectors++; if (now !== 4'd15) begin errors++; $display("FAIL wrap_now15: got %0d, expected 15", now); end
    deq_count = 0;
    deq_now.delete();
    load(14, 8'hE1);
    step();
    vectors++; if (deq_count != 1 || deq_now.size() != 1 || deq_now[$] != 15) begin errors++; $display("FAIL wrap_k14: got %0d pops, expected 1 at now=15", deq_count); end
    load(1, 8'h15);
    repeat (3) step();
    vectors++; if (deq_count != 1) begin errors++; $display("FAIL wrap_k1_early: got %0d pops, expected 1", deq_count); end
    tick = 1'b1;
    repeat (2) step();
    tick = 1'b0;
    vectors++; if (now !== 4'd1) begin errors++; $display("FAIL wrap_now1: got %0d, expected 1", now); end
    step();
    vectors++; if (deq_count != 2 || deq_now[$] != 1) begin errors++; $display("FAIL wrap_k1: got %0d pops, expected 2 with last at now=1", deq_count); end
    repeat (2) step();
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_left: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    int fd_cyc;
    apply_reset();
    bus.m_ready = 1'b1;
    deq_cyc.delete();
    load(5, 8'h55);
    load(12, 8'hCC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    fd_cyc = -1;
    for (int i = 0; i < 10 && fd_cyc < 0; i++) begin
      step();
      if (flush_done) fd_cyc = cyc;
    end
    vectors++;
    if (deq_cyc.size() != 2) begin
      errors++; $display("FAIL fl_deqs: got %0d pops, expected 2", deq_cyc.size());
    end else begin
      if (deq_cyc[1] != deq_cyc[0] + 1) begin errors++; $display("FAIL fl_b2b: pops at cycles %0d,%0d, expected adjacent", deq_cyc[0], deq_cyc[1]); end
      if (fd_cyc != deq_cyc[1] + 2) begin errors++; $display("FAIL fl_done: pulse at cycle %0d, expected %0d", fd_cyc, deq_cyc[1] + 2); end
    end
    step();
    vectors++; if (flush_done !== 1'b0) begin errors++; $display("FAIL fl_pulse: got %b, expected 0", flush_done); end
    vectors++; if (now !== 4'd0) begin errors++; $display("FAIL fl_now: got %0d, expected 0", now); end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL fl_left: %0d left, expected 0", exp_q.size()); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++; if (flush_done !== 1'b0) begin errors++; $display("FAIL fl_empty_early: got %b, expected 0", flush_done); end
    step();
    vectors++; if (flush_done !== 1'b1) begin errors++; $display("FAIL fl_empty_done: got %b, expected 1", flush_done); end
    deq_count = 0;
    load(0, 8'h77);
    repeat (3) step();
    vectors++; if (deq_count != 0) begin errors++; $display("FAIL fl_stop: got %0d pops, expected 0", deq_count); end
  endtask

  task automatic test_saturate();
    apply_reset();
    en = 1'b1;
    bus.m_ready = 1'b1;
    deq_count = 0;
    for (int i = 0; i < 5; i++) load(0, 8'h60 + i);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step();
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat_timeout: %0d left, expected 0", exp_q.size()); end
    vectors++; if (deq_count != 5) begin errors++; $display("FAIL sat_deqs: got %0d, expected 5", deq_count); end
    vectors++; if (rel_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d, expected 3", rel_cnt); end
    repeat (3) step();
    vectors++; if (rel_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d, expected 3", rel_cnt); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_backpressure();
    test_wrap();
    test_flush();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
